// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode type and constants, data width, and the
// team ALU function used by the arbitrated datapath.
package alu_pkg;

  localparam int DATA_W = 8;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_ADD    = 3'b000;
  localparam opcode_t OP_SUB    = 3'b001;
  localparam opcode_t OP_AND    = 3'b010;
  localparam opcode_t OP_PASS_B = 3'b011;

  // Codes 100..111 are reserved; they all have the top bit set.
  function automatic logic op_is_illegal(input opcode_t op);
    return op[2];
  endfunction

  // Team ALU: modulo-2^DATA_W arithmetic, carry/borrow dropped,
  // reserved codes produce zero.
  function automatic logic [DATA_W-1:0] alu_exec(input opcode_t           op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    logic [DATA_W-1:0] r;
    case (op)
      OP_ADD:    r = a + b;
      OP_SUB:    r = a - b;
      OP_AND:    r = a & b;
      OP_PASS_B: r = b;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_rr_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches req_i starting at
// ptr_i, wrapping from N-1 back to 0, and returns the first set bit as a
// one-hot grant plus its index.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] grant_idx_o,
  output logic          any_grant_o
);

  // Walk the N candidate positions in priority order; first hit wins.
  always_comb begin
    logic [IW:0]   pos;
    logic [IW-1:0] idx;
    grant_o     = '0;
    grant_idx_o = '0;
    any_grant_o = 1'b0;
    pos         = '0;
    idx         = '0;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, ptr_i} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      idx = pos[IW-1:0];
      if (!any_grant_o && req_i[idx]) begin
        any_grant_o  = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = idx;
      end
    end
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter: shares one ALU between N_REQ requesters with round-robin
// arbitration. The granted operation executes combinationally and lands in
// a single-entry response register tagged with the requester index.
// Optional build macro ALU_ARB_ILLEGAL_OP_EN adds the rsp_err output that
// flags a captured reserved opcode.
module alu_rr_arbiter
  import alu_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [3*N_REQ-1:0]      req_op,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [DATA_W-1:0]       rsp_result,
  output logic                    rsp_zero
`ifdef ALU_ARB_ILLEGAL_OP_EN
  ,
  output logic                    rsp_err
`endif
);

  logic [ID_W-1:0]   ptr_q, ptr_d;
  logic              valid_q, valid_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              zero_q, zero_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic              err_q, err_d;
`endif

  logic [N_REQ-1:0]  grant;
  logic [ID_W-1:0]   grant_idx;
  logic              any_grant;
  logic              accept;
  logic              xfer;

  opcode_t           sel_op;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [DATA_W-1:0] alu_res;

  rr_pick #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_pick (
    .req_i       (req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_grant_o (any_grant)
  );

  // The register can take a new result when empty or being drained now;
  // ready is forced low while reset is asserted.
  always_comb begin
    accept    = !valid_q || rsp_ready;
    req_ready = (rst_n && accept) ? grant : '0;
    xfer      = rst_n && accept && any_grant;
  end

  // Operand mux keyed by the grant index.
  always_comb begin
    sel_op = OP_ADD;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_op = req_op[3*i +: 3];
        sel_a  = req_a[DATA_W*i +: DATA_W];
        sel_b  = req_b[DATA_W*i +: DATA_W];
      end
    end
    alu_res = alu_exec(sel_op, sel_a, sel_b);
  end

  // Response register and priority pointer next state. The pointer only
  // moves on a transfer, to the slot after the winner.
  always_comb begin
    ptr_d    = ptr_q;
    valid_d  = valid_q;
    id_d     = id_q;
    result_d = result_q;
    zero_d   = zero_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
    err_d    = err_q;
`endif
    if (xfer) begin
      valid_d  = 1'b1;
      id_d     = grant_idx;
      result_d = alu_res;
      zero_d   = (alu_res == '0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_d    = op_is_illegal(sel_op);
`endif
      if (grant_idx == ID_W'(N_REQ-1)) ptr_d = '0;
      else                             ptr_d = grant_idx + ID_W'(1);
    end else if (valid_q && rsp_ready) begin
      valid_d = 1'b0;
    end
  end

  // State registers; reset discards any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q    <= '0;
      valid_q  <= 1'b0;
      id_q     <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_q    <= 1'b0;
`endif
    end else begin
      ptr_q    <= ptr_d;
      valid_q  <= valid_d;
      id_q     <= id_d;
      result_q <= result_d;
      zero_q   <= zero_d;
`ifdef ALU_ARB_ILLEGAL_OP_EN
      err_q    <= err_d;
`endif
    end
  end

  assign rsp_valid  = valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  assign rsp_err    = err_q;
`endif

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Testbench for alu_rr_arbiter: directed vectors with literal expectations
// plus a behavioural reference model checked every negative clock edge.
module tb_alu_rr_arbiter;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [N-1:0] req_valid = '0;
  logic [N-1:0] req_ready;
  logic [3*N-1:0] req_op = '0;
  logic [8*N-1:0] req_a = '0;
  logic [8*N-1:0] req_b = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [1:0]   rsp_id;
  logic [7:0]   rsp_result;
  logic         rsp_zero;
`ifdef ALU_ARB_ILLEGAL_OP_EN
  logic         rsp_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.N_REQ(N)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_ILLEGAL_OP_EN
    ,
    .rsp_err    (rsp_err)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_ptr = 0, m_valid = 0, m_id = 0, m_result = 0, m_zero = 0, m_err = 0;

  function automatic int m_grant();
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic int m_alu(input int op, input int a, input int b);
    case (op)
      0: return (a + b) % 256;
      1: return (a - b + 256) % 256;
      2: return a & b;
      3: return b;
      default: return 0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ptr = 0; m_valid = 0; m_id = 0; m_result = 0; m_zero = 0; m_err = 0;
    end else begin
      int g;
      g = m_grant();
      if ((m_valid == 0 || rsp_ready) && g >= 0) begin
        m_valid  = 1;
        m_id     = g;
        m_result = m_alu(int'(req_op[3*g +: 3]), int'(req_a[8*g +: 8]), int'(req_b[8*g +: 8]));
        m_zero   = (m_result == 0) ? 1 : 0;
        m_err    = (int'(req_op[3*g +: 3]) >= 4) ? 1 : 0;
        m_ptr    = (g + 1) % N;
      end else if (m_valid != 0 && rsp_ready) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clk) begin
    int g;
    int exp_ready;
    g = m_grant();
    exp_ready = (rst_n && (m_valid == 0 || rsp_ready) && g >= 0) ? (1 << g) : 0;
    chk("model_ready", 32'(req_ready), 32'(exp_ready));
    chk("model_rsp_valid", 32'(rsp_valid), 32'(m_valid));
    chk("model_rsp_id", 32'(rsp_id), 32'(m_id));
    chk("model_rsp_result", 32'(rsp_result), 32'(m_result));
    chk("model_rsp_zero", 32'(rsp_zero), 32'(m_zero));
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("model_rsp_err", 32'(rsp_err), 32'(m_err));
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*i +: 3] = op;
    req_a[8*i +: 8]  = a;
    req_b[8*i +: 8]  = b;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_rsp(input string name, input int id, input logic [7:0] res, input logic zero);
    chk({name, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, "_id"}, 32'(rsp_id), 32'(id));
    chk({name, "_result"}, 32'(rsp_result), 32'(res));
    chk({name, "_zero"}, 32'(rsp_zero), 32'(zero));
  endtask

  initial begin
    logic [7:0] fair_res [4];
    fair_res = '{8'h01, 8'h11, 8'h21, 8'h31};

    // Reset state
    #12;
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    chk("reset_ready", 32'(req_ready), 32'd0);
    chk("reset_valid", 32'(rsp_valid), 32'd0);
    chk("reset_result", 32'(rsp_result), 32'd0);
    req_valid = '0;
    tick();
    rst_n = 1'b1;
    tick();

    // Fairness: all requesters valid, consumer always ready
    for (int i = 0; i < N; i++) set_req(i, 3'b000, 8'(16*i), 8'h01);
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("fair_grant", 32'(req_ready), 32'(1 << (k % 4)));
      if (k > 0) chk_rsp("fair_rsp", (k - 1) % 4, fair_res[(k - 1) % 4], 1'b0);
      tick();
    end
    req_valid = '0;

    // Single request (ptr=2, search wraps to 0)
    set_req(0, 3'b000, 8'h0F, 8'h01);
    req_valid = 4'b0001;
    #1 chk("single_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1 chk_rsp("single_rsp", 0, 8'h10, 1'b0);
    tick();

    // Zero result and wrap-around arithmetic
    set_req(3, 3'b001, 8'h05, 8'h05);
    req_valid = 4'b1000;
    #1 chk("sub_ready", 32'(req_ready), 32'h8);
    tick();
    req_valid = '0;
    #1 chk_rsp("sub_zero", 3, 8'h00, 1'b1);
    set_req(0, 3'b000, 8'hFF, 8'h02);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #1 chk_rsp("add_wrap", 0, 8'h01, 1'b0);

    // Back-pressure with 2 and 3 pending
    set_req(1, 3'b011, 8'h00, 8'h77);
    req_valid = 4'b0010;
    #1 chk("bp_load_ready", 32'(req_ready), 32'h2);
    tick();
    set_req(2, 3'b010, 8'hF0, 8'h3C);
    set_req(3, 3'b000, 8'h01, 8'h01);
    req_valid = 4'b1100;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("bp_ready", 32'(req_ready), 32'h0);
      chk_rsp("bp_hold", 1, 8'h77, 1'b0);
      tick();
    end
    rsp_ready = 1'b1;
    #1 chk("bp_release_grant2", 32'(req_ready), 32'h4);
    tick();
    #1 chk("bp_next_grant3", 32'(req_ready), 32'h8);
    chk_rsp("bp_rsp2", 2, 8'h30, 1'b0);
    tick();
    req_valid = '0;
    #1 chk_rsp("bp_rsp3", 3, 8'h02, 1'b0);

    // Reserved opcode, then a legal one
    set_req(0, 3'b110, 8'hAA, 8'h55);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #1 chk_rsp("illegal", 0, 8'h00, 1'b1);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("illegal_err", 32'(rsp_err), 32'd1);
`endif
    set_req(1, 3'b000, 8'h01, 8'h02);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    #1 chk_rsp("legal_after", 1, 8'h03, 1'b0);
`ifdef ALU_ARB_ILLEGAL_OP_EN
    chk("legal_err", 32'(rsp_err), 32'd0);
`endif

    // Reset while a response is held under back-pressure
    set_req(2, 3'b000, 8'h03, 8'h04);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    rsp_ready = 1'b0;
    #1 chk_rsp("pre_reset", 2, 8'h07, 1'b0);
    tick();
    set_req(0, 3'b000, 8'h07, 8'h08);
    req_valid = 4'b0011;
    rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_valid", 32'(rsp_valid), 32'd0);
    chk("rst_id", 32'(rsp_id), 32'd0);
    chk("rst_result", 32'(rsp_result), 32'd0);
    chk("rst_zero", 32'(rsp_zero), 32'd0);
    tick();
    rst_n = 1'b1;
    #1 chk("post_rst_grant0", 32'(req_ready), 32'h1);
    tick();
    req_valid = '0;
    #1 chk_rsp("post_rst_rsp", 0, 8'h0F, 1'b0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
